// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM access controller: op encodings, FSM
// state encoding and default geometry.
package mem_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int MEM_DEPTH_DEF  = 32;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_WB    = 2'd3;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU request at a time (READ, WRITE, INC)
// onto a single-port synchronous SRAM with active-low write enable and a
// one-cycle registered read.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req, op, addr, wdata  request (sampled only while idle)
//   busy                high while a request is in flight
//   done                one-cycle completion pulse
//   rdata, zero, err    completion results (valid with done)
//   mem_we_n, mem_addr, mem_wdata  registered SRAM drive
//   mem_rdata           SRAM registered read data
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  zero,
  output logic                  err,
  output logic                  mem_we_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // One extra bit so the depth compare stays correct when MEM_DEPTH is a
  // full power of two of the address space.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  zero_q, zero_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  we_n_q, we_n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  bad_req;
  logic [DATA_WIDTH-1:0] inc_sum;

  assign bad_req = (op == OP_RSVD) || ({1'b0, addr} >= DEPTH_W);
  assign inc_sum = mem_rdata + 1'b1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    done_d  = 1'b0;
    err_d   = err_q;
    zero_d  = zero_q;
    rdata_d = rdata_q;
    we_n_d  = 1'b1;     // write enable only ever pulses for one cycle
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_d    = op;
          if (bad_req) begin
            // Rejected in place: no SRAM cycle, rdata kept.
            done_d = 1'b1;
            err_d  = 1'b1;
            zero_d = 1'b0;
          end else begin
            we_n_d  = (op != OP_WRITE);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (op_q == OP_WRITE) begin
          // SRAM commits on this edge.
          done_d  = 1'b1;
          err_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          // SRAM registers mem[addr] on this edge.
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (op_q == OP_INC) begin
          wdata_d = inc_sum;
          rdata_d = inc_sum;
          zero_d  = (inc_sum == '0);
          we_n_d  = 1'b0;
          state_d = ST_WB;
        end else begin
          rdata_d = mem_rdata;
          done_d  = 1'b1;
          err_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        done_d  = 1'b1;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      done_q  <= done_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign zero      = zero_q;
  assign rdata     = rdata_q;
  assign mem_we_n  = we_n_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural SRAM model.
module tb_mem_access_ctrl;

  logic        clk, rst, req;
  logic [1:0]  op;
  logic [15:0] addr, wdata;
  logic        busy, done, zero, err, mem_we_n;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  mem_access_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .zero(zero), .err(err),
    .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: active-low write, registered read-first output, no reset.
  logic [15:0] sram [32];
  always @(posedge clk) begin
    if (!mem_we_n && mem_addr < 16'd32) sram[mem_addr[4:0]] <= mem_wdata;
    mem_rdata <= (mem_addr < 16'd32) ? sram[mem_addr[4:0]] : 16'h0;
  end

  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic        zero;
    logic        err;
    int          lat;
    int          we_lows;
    int          req_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [32];
  logic [15:0] last_rdata;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          we_lows = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference model: the outcome of a request follows directly from the op,
  // the address range and the word currently stored.
  task automatic model(input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] d, output exp_t e);
    logic [15:0] v;
    e.zero = 1'b0; e.err = 1'b0; e.we_lows = 0;
    if (o == 2'b11 || a >= 16'd32) begin
      e.name = "err"; e.err = 1'b1; e.lat = 1;
    end else if (o == 2'b01) begin
      e.name = "write"; ref_mem[a[4:0]] = d; e.lat = 2; e.we_lows = 1;
    end else if (o == 2'b00) begin
      e.name = "read"; last_rdata = ref_mem[a[4:0]]; e.lat = 3;
    end else begin
      e.name = "inc"; v = ref_mem[a[4:0]] + 16'd1;
      ref_mem[a[4:0]] = v; last_rdata = v;
      e.zero = (v == 16'h0); e.lat = 4; e.we_lows = 1;
    end
    e.rdata = last_rdata;
  endtask

  // Called at a negedge; returns at the negedge after the request edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int g = 0;
    while (busy && g < 20) begin @(negedge clk); g++; end
    if (busy) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_wait: busy got 1 required 0");
      return;
    end
    model(o, a, d, e);
    e.req_cyc = cyc;
    sb.push_back(e);
    req = 1'b1; op = o; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 40) begin @(negedge clk); g++; end
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: pending got %0d required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      we_lows = 0;
    end else begin
      if (!mem_we_n) we_lows++;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got done=1 required 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_rdata"}, 32'(rdata), 32'(e.rdata));
          chk({e.name, "_zero"},  32'(zero),  32'(e.zero));
          chk({e.name, "_err"},   32'(err),   32'(e.err));
          chk({e.name, "_lat"},   32'(cyc - e.req_cyc), 32'(e.lat));
          chk({e.name, "_we_lows"}, 32'(we_lows), 32'(e.we_lows));
        end
        we_lows = 0;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);
    chk({tag, "_zero"}, 32'(zero), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_we_n"}, 32'(mem_we_n), 1);
    chk({tag, "_maddr"}, 32'(mem_addr), 0);
    chk({tag, "_mwdata"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [1:0]  ro;
    logic [15:0] ra;
    rst = 1'b1; req = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    last_rdata = '0;
    for (int i = 0; i < 32; i++) begin sram[i] = 16'h0; ref_mem[i] = 16'h0; end
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Write then read back.
    issue(2'b01, 16'd5, 16'hA5A5);
    issue(2'b00, 16'd5, 16'h0);
    drain();

    // INC wrap to zero and a plain increment.
    issue(2'b01, 16'd7, 16'hFFFF);
    issue(2'b10, 16'd7, 16'h0);
    issue(2'b00, 16'd7, 16'h0);
    issue(2'b01, 16'd8, 16'h0041);
    issue(2'b10, 16'd8, 16'h0);
    drain();

    // Rejections: out-of-range address and reserved op.
    issue(2'b01, 16'd3, 16'h1234);
    issue(2'b00, 16'd32, 16'h0);
    issue(2'b11, 16'd3, 16'hDEAD);
    issue(2'b00, 16'd3, 16'h0);
    drain();

    // Back-to-back in the done cycle, then a busy-time pulse that is dropped.
    d0 = done_cnt;
    issue(2'b01, 16'd10, 16'h1111);
    while (busy) @(negedge clk);
    chk("b2b_done_cycle", 32'(done), 1);
    issue(2'b01, 16'd11, 16'h2222);
    req = 1'b1; op = 2'b01; addr = 16'd12; wdata = 16'hBAD0;
    @(negedge clk);
    req = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 2);

    // Reset during the write-back of an INC: nothing commits, no done.
    issue(2'b01, 16'd9, 16'h0010);
    drain();
    req = 1'b1; op = 2'b10; addr = 16'd9;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("wb_we_low", 32'(mem_we_n), 0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("rst_we_n_immediate", 32'(mem_we_n), 1);
    last_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 0);
    chk_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    issue(2'b00, 16'd9, 16'h0);
    issue(2'b00, 16'd0, 16'h0);
    drain();

    // Randomised traffic, with occasional dropped busy-time pulses.
    for (int n = 0; n < 250; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(32, 16'hFFFF))
                                       : 16'($urandom_range(0, 31));
      issue(ro, ra, 16'($urandom));
      if (busy && $urandom_range(0, 3) == 0) begin
        req = 1'b1; op = 2'($urandom_range(0, 3));
        addr = 16'($urandom_range(0, 31)); wdata = 16'($urandom);
        @(negedge clk);
        req = 1'b0;
      end
    end
    drain();

    // Full read-back against the model.
    for (int i = 0; i < 32; i++) issue(2'b00, 16'(i), 16'h0);
    drain();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side controller that sequences CPU memory requests onto the single-port synchronous SRAM. The SRAM has an active-low write enable and a registered read with one clock of latency.
- Accepts one request at a time over a req/done handshake.
- Supports READ, WRITE and INC. INC is a read-modify-write for the ISZ instruction and returns a zero flag.
- Sits between the CPU control unit and the memory array; it is the only driver of the SRAM port.

Parameters:
ADDR_WIDTH, 16, width of CPU and SRAM address
DATA_WIDTH, 16, width of data words
MEM_DEPTH, 32, number of implemented SRAM words; addresses >= MEM_DEPTH are errors

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req  input  1  request strobe; sampled only when busy=0
op  input  2  00 READ, 01 WRITE, 10 INC, 11 reserved
addr  input  ADDR_WIDTH  request address
wdata  input  DATA_WIDTH  write data (WRITE only)
busy  output  1  high while state != IDLE (combinational from state)
done  output  1  one-cycle completion pulse (registered)
rdata  output  DATA_WIDTH  read result (READ: mem word; INC: incremented word); held until next completion
zero  output  1  INC result == 0; cleared on every other completion
err  output  1  request rejected (bad addr or reserved op); valid with done
mem_we_n  output  1  SRAM write enable, active low, registered
mem_addr  output  ADDR_WIDTH  SRAM address, registered
mem_wdata  output  DATA_WIDTH  SRAM write data, registered
mem_rdata  input  DATA_WIDTH  SRAM registered read data

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - mem_we_n=1, mem_addr=0, mem_wdata=0.
  - done=0, rdata=0, zero=0, err=0.
  - A reset mid-operation aborts the access: no done, no write commit after reset assertion.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE, req=1 sampled at edge E0:
  - Latch addr into mem_addr and wdata into mem_wdata.
  - If op=11 or addr>=MEM_DEPTH: stay IDLE; done=1, err=1, rdata unchanged, zero=0; no SRAM access; mem_we_n stays 1.
  - WRITE: mem_we_n<=0, go to ISSUE.
  - READ/INC: mem_we_n stays 1, go to ISSUE.
- ISSUE:
  - WRITE: the SRAM commits at E1. Set mem_we_n<=1, go to IDLE, done=1 after E1.
  - READ/INC: the SRAM registers mem[addr] at E1. Go to WAIT.
- WAIT:
  - READ: at E2 capture rdata<=mem_rdata, done=1, go to IDLE.
  - INC: at E2 set mem_wdata<=mem_rdata+1 (mod 2^DATA_WIDTH), rdata<=the same value, zero<=(sum==0), mem_we_n<=0, go to WB.
- WB: the SRAM commits at E3. mem_we_n<=1, done=1, go to IDLE.
- Latency (req edge to done visible): WRITE 1 cycle after E1; READ after E2; INC after E3; error after E0.
- done is high exactly one cycle. The controller is back in IDLE while done is high, so a req in that cycle is accepted (back-to-back allowed).
- req while busy=1 is ignored (not queued).
- mem_addr holds its value between requests; mem_we_n is never low outside ISSUE(WRITE) and WB.
- err=0 and zero=0 on every successful non-INC completion.

Decomposition:
- Shared package mem_pkg:
  - op encodings OP_READ, OP_WRITE, OP_INC, OP_RSVD.
  - State encoding typedef.
  - Default ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH constants.
- No sub-module needed; a single FSM with a datapath register block.
- The bench instantiates mem_access_ctrl with the existing sram as the memory model.

Test Plan:
- WRITE addr=5 wdata=16'hA5A5, then READ addr=5 -> write done 2 edges after req, read done 3 edges after req, rdata=16'hA5A5, err=0, zero=0.
- INC at addr=7 preloaded 16'hFFFF -> done at E3, rdata=16'h0000, zero=1; subsequent READ addr=7 returns 16'h0000. INC on 16'h0041 -> rdata=16'h0042, zero=0.
- READ addr=32 (MEM_DEPTH) and op=11 at addr=3 -> done one cycle after req with err=1; mem_we_n never low; SRAM contents unchanged.
- Back-to-back: assert req during the done cycle of a WRITE, then pulse req while busy -> second request accepted immediately; the busy-time pulse is ignored (exactly two done pulses).
- Reset asserted during WB of an INC -> mem_we_n=1 immediately, no done; memory retains the pre-INC value 16'h0010 when read after reset.
- After reset release -> all outputs at reset values; first READ addr=0 completes normally.
